// File: rtl/neuron_mac_accumulator_if.sv
// Operand stream and result bus between a neuron MAC engine and its producer/consumer.
// Latency: none, wires only.
// Backpressure: the slave raises in_ready; a pair moves only when in_valid && in_ready.
interface neuron_mac_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w;
    logic                     in_ready;
    logic                     busy;
    logic                     done;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf;

    modport master (
        output start, in_valid, x, w,
        input  in_ready, busy, done, sum, ovf
    );

    modport slave (
        input  start, in_valid, x, w,
        output in_ready, busy, done, sum, ovf
    );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Neuron MAC: accumulates N_INPUTS signed x*w products; MAC_SAT_EN selects saturating math + sticky ovf.
// Latency: done pulses and sum updates the cycle after the last accepted pair.
// Backpressure: in_ready is high only in ACC; pairs offered in IDLE/DONE are left unconsumed.
module neuron_mac_accumulator #(
    parameter int N_INPUTS = 16,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20
) (
    input logic                     clk,
    input logic                     rst,
    neuron_mac_accumulator_if.slave bus
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam int PRD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     accept;
    logic                     last_term;
    logic signed [PRD_W-1:0]  prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     sat_hit;

    assign accept    = bus.in_valid && (state_q == S_ACC);
    assign last_term = (count_q == CNT_W'(N_INPUTS - 1));

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] acc_wide;
    logic                  ovf_q, ovf_d;

    // Product and one-bit-wider sum; the top two bits disagreeing means the ACC_W result overflowed.
    always_comb begin
        prod     = PRD_W'(bus.x) * PRD_W'(bus.w);
        prod_ext = ACC_W'(prod);
        acc_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
        sat_hit  = acc_wide[ACC_W] != acc_wide[ACC_W-1];
        acc_nxt  = acc_wide[ACC_W-1:0];
        if (sat_hit) begin
            acc_nxt = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Overflow flag: cleared by a new evaluation, set by any clamp, otherwise sticky.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_IDLE && bus.start) begin
            ovf_d = 1'b0;
        end else if (accept && sat_hit) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    // Product and plain two's-complement wrap-around sum.
    always_comb begin
        prod     = PRD_W'(bus.x) * PRD_W'(bus.w);
        prod_ext = ACC_W'(prod);
        acc_nxt  = acc_q + prod_ext;
        sat_hit  = 1'b0;
    end

    assign bus.ovf = 1'b0;
`endif

    // Next-state logic: IDLE waits for start, ACC folds in accepted pairs, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d   = acc_nxt;
                    count_d = count_q + CNT_W'(1);
                    if (last_term) begin
                        // sum is loaded only here so it is stable from DONE until the next DONE.
                        sum_d   = acc_nxt;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, accumulator, term counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.in_ready = (state_q == S_ACC);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.sum      = sum_q;

    // Width-only use of sat_hit in the wrap build keeps both builds structurally alike.
    logic unused_ok;
    assign unused_ok = sat_hit;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench for neuron_mac_accumulator with N_INPUTS=4 and N_INPUTS=32 instances.
// Expected results are queued when a vector is driven and compared when done pulses.
module tb_neuron_mac_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_mac_accumulator_if #(.DATA_W(8), .ACC_W(20)) if4 ();
    neuron_mac_accumulator_if #(.DATA_W(8), .ACC_W(20)) if32 ();

    neuron_mac_accumulator #(.N_INPUTS(4), .DATA_W(8), .ACC_W(20)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    neuron_mac_accumulator #(.N_INPUTS(32), .DATA_W(8), .ACC_W(20)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    typedef struct packed {
        logic [19:0] sum;
        logic        ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q32[$];
    exp_t e4, e32;

    int checks    = 0;
    int failures  = 0;
    int done4_cnt = 0;
    int done32_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic signed [7:0] xv, input logic signed [7:0] wv);
        if4.in_valid = v;
        if4.x        = xv;
        if4.w        = wv;
        tick();
    endtask

    task automatic start4();
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
    endtask

    task automatic wait_done4(input string tag, input int budget);
        int n;
        n = 0;
        while (if4.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(if4.done), 32'd1);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if4.done === 1'b1) begin
            done4_cnt++;
            check("sb4_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("sb4_sum", 32'($unsigned(if4.sum)), 32'(e4.sum));
                check("sb4_ovf", 32'(if4.ovf), 32'(e4.ovf));
            end
        end
        if (if32.done === 1'b1) begin
            done32_cnt++;
            check("sb32_expected", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                e32 = q32.pop_front();
                check("sb32_sum", 32'($unsigned(if32.sum)), 32'(e32.sum));
                check("sb32_ovf", 32'(if32.ovf), 32'(e32.ovf));
            end
        end
    end

    initial begin
        int d0;
        logic [4:0] vpat [7];

        if4.start = 1'b0;  if4.in_valid = 1'b0;  if4.x = '0;  if4.w = '0;
        if32.start = 1'b0; if32.in_valid = 1'b0; if32.x = '0; if32.w = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(if4.in_ready), 32'd0);
        check("rst_busy",     32'(if4.busy),     32'd0);
        check("rst_done",     32'(if4.done),     32'd0);
        check("rst_sum",      32'($unsigned(if4.sum)), 32'd0);
        check("rst_ovf",      32'(if4.ovf),      32'd0);

        // 1. Basic sum: 1*2+2*2+3*2+4*2 = 20
        start4();
        check("t1_in_ready_acc", 32'(if4.in_ready), 32'd1);
        check("t1_busy_acc",     32'(if4.busy),     32'd1);
        q4.push_back('{sum: 20'h00014, ovf: 1'b0});
        for (int i = 1; i <= 4; i++) begin
            check("t1_no_early_done", 32'(if4.done), 32'd0);
            drive4(1'b1, 8'(i), 8'sd2);
        end
        if4.in_valid = 1'b0;
        check("t1_done_latency", 32'(if4.done), 32'd1);
        check("t1_done_busy",    32'(if4.busy), 32'd1);
        check("t1_done_ready",   32'(if4.in_ready), 32'd0);
        tick();
        check("t1_busy_fall",    32'(if4.busy), 32'd0);
        check("t1_done_fall",    32'(if4.done), 32'd0);
        check("t1_sum_hold",     32'($unsigned(if4.sum)), 32'h00014);

        // 2. Negative products: 4 * (-128*127) = -65024
        start4();
        q4.push_back('{sum: 20'hF0200, ovf: 1'b0});
        for (int i = 0; i < 4; i++) drive4(1'b1, -8'sd128, 8'sd127);
        if4.in_valid = 1'b0;
        wait_done4("t2_done", 4);
        tick();

        // 3. Overflow on the 32-term instance: true total 524288
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
`ifdef MAC_SAT_EN
        q32.push_back('{sum: 20'h7FFFF, ovf: 1'b1});
`else
        q32.push_back('{sum: 20'h80000, ovf: 1'b0});
`endif
        for (int i = 0; i < 32; i++) begin
            if32.in_valid = 1'b1;
            if32.x = -8'sd128;
            if32.w = -8'sd128;
            tick();
        end
        if32.in_valid = 1'b0;
        check("t3_done", 32'(if32.done), 32'd1);
`ifdef MAC_SAT_EN
        check("t3_ovf", 32'(if32.ovf), 32'd1);
`else
        check("t3_ovf", 32'(if32.ovf), 32'd0);
`endif
        tick();

        // 4. Valid gaps plus a start pulse mid-evaluation: 4 accepts of 5*-1
        d0 = done4_cnt;
        start4();
        q4.push_back('{sum: 20'hFFFEC, ovf: 1'b0});
        vpat = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd1};
        for (int i = 0; i < 7; i++) begin
            if4.start = (i == 2);
            drive4(vpat[i][0], 8'sd5, -8'sd1);
        end
        if4.start = 1'b0;
        check("t4_done_after_4th", 32'(if4.done), 32'd1);
        // Offered pairs in IDLE are ignored
        if4.in_valid = 1'b1;
        tick();
        tick();
        check("t4_idle_ready", 32'(if4.in_ready), 32'd0);
        check("t4_idle_busy",  32'(if4.busy), 32'd0);
        check("t4_done_once",  32'(done4_cnt - d0), 32'd1);
        check("t4_sum_hold",   32'($unsigned(if4.sum)), 32'hFFFEC);
        if4.in_valid = 1'b0;

        // 5. Reset mid-evaluation, then restart with four 1*1 terms
        d0 = done4_cnt;
        start4();
        drive4(1'b1, 8'sd9, 8'sd9);
        drive4(1'b1, 8'sd9, 8'sd9);
        if4.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_busy",  32'(if4.busy), 32'd0);
        check("t5_rst_ready", 32'(if4.in_ready), 32'd0);
        check("t5_rst_sum",   32'($unsigned(if4.sum)), 32'd0);
        check("t5_rst_ovf",   32'(if4.ovf), 32'd0);
        tick();
        check("t5_no_done",   32'(done4_cnt - d0), 32'd0);
        start4();
        q4.push_back('{sum: 20'h00004, ovf: 1'b0});
        for (int i = 0; i < 4; i++) drive4(1'b1, 8'sd1, 8'sd1);
        if4.in_valid = 1'b0;
        wait_done4("t5_done", 4);

        // 6. Back-to-back: 4*9=36 then 4*(-14)=-56
        tick();
        start4();
        q4.push_back('{sum: 20'h00024, ovf: 1'b0});
        for (int i = 0; i < 4; i++) drive4(1'b1, 8'sd3, 8'sd3);
        if4.in_valid = 1'b0;
        wait_done4("t6_done1", 4);
        tick();
        start4();
        check("t6_restart_busy", 32'(if4.busy), 32'd1);
        q4.push_back('{sum: 20'hFFFC8, ovf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            check("t6_sum_hold", 32'($unsigned(if4.sum)), 32'h00024);
            drive4(1'b1, -8'sd2, 8'sd7);
        end
        if4.in_valid = 1'b0;
        wait_done4("t6_done2", 4);
        tick();
        tick();

        check("q4_drained",  32'(q4.size()),  32'd0);
        check("q32_drained", 32'(q32.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
